// File: rtl/ppu_requant_stream.sv
// ppu_requant_stream: multi-lane streaming requantiser (alpha multiply, beta shift, round-half-up, ReLU, saturate)
// Ports: cfg_* write the per-channel alpha/beta table and set the quasi-static mode (relu, groups per pass),
//        in_* carry LANES signed partial sums per beat (valid/ready, in_last marks the end of a pass),
//        out_* carry LANES requantised values per beat (valid/ready, out_last follows in_last),
//        sat_count counts saturated lanes and is cleared by cfg_sat_clr.
// Optional: define PPU_SAT_STATS_EN to build sat_count; when undefined it is tied to 0.
module ppu_requant_stream #(
    parameter int LANES       = 4,
    parameter int PSUM_WIDTH  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int ALPHA_WIDTH = 8,
    parameter int BETA_WIDTH  = 4,
    parameter int NUM_CH      = 64,
    parameter int GRP_W       = $clog2(NUM_CH / LANES) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_relu,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]   cfg_addr,
    input  logic [ALPHA_WIDTH-1:0]      cfg_alpha,
    input  logic [BETA_WIDTH-1:0]       cfg_beta,
    input  logic [GRP_W-1:0]            cfg_num_grp,
    input  logic                        cfg_sat_clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*PSUM_WIDTH-1:0] in_psum,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic [15:0]                 sat_count
);
    localparam int AW = $clog2(NUM_CH);
    localparam int PW = PSUM_WIDTH + ALPHA_WIDTH + 1;
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] UMAX = RW'((1 << DATA_WIDTH) - 1);
    localparam logic signed [RW-1:0] SMAX = RW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] SMIN = ~SMAX;
    logic [ALPHA_WIDTH-1:0] alpha [NUM_CH];
    logic [BETA_WIDTH-1:0] beta [NUM_CH];
    logic en, v1, v2, last1, last2;
    logic [GRP_W-1:0] grp, ngrp;
    logic [AW-1:0] idx [LANES];
    logic signed [PSUM_WIDTH-1:0] ps [LANES];
    logic signed [PW-1:0] prod [LANES], p1 [LANES], t2 [LANES];
    logic [BETA_WIDTH-1:0] b1 [LANES];
    logic signed [RW-1:0] rnd [LANES], r2 [LANES], lo, hi;
    logic [DATA_WIDTH-1:0] q [LANES];

    assign en = ~out_valid | out_ready;
    assign in_ready = en;
    assign ngrp = (cfg_num_grp == '0) ? GRP_W'(1) : cfg_num_grp;

    always_comb begin
        lo = cfg_relu ? '0 : SMIN;
        hi = cfg_relu ? UMAX : SMAX;
        for (int l = 0; l < LANES; l++) begin
            ps[l] = in_psum[l*PSUM_WIDTH +: PSUM_WIDTH];
            idx[l] = AW'(int'(grp) * LANES + l);
            prod[l] = $signed({1'b0, alpha[idx[l]]}) * ps[l];
            if (cfg_relu && ps[l] < 0) prod[l] = '0;
            // shifting by beta-1 first leaves the rounding bit at bit 0
            t2[l] = (b1[l] == '0) ? p1[l] : p1[l] >>> (b1[l] - 1'b1);
            rnd[l] = (b1[l] == '0) ? RW'(t2[l]) : RW'(t2[l] >>> 1) + RW'(t2[l][0]);
            q[l] = (r2[l] < lo) ? lo[DATA_WIDTH-1:0] : (r2[l] > hi) ? hi[DATA_WIDTH-1:0] : r2[l][DATA_WIDTH-1:0];
        end
    end

    // table reads happen before the edge that commits a write, so a colliding beat sees the old entry
    always_ff @(posedge clk)
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                alpha[i] <= ALPHA_WIDTH'(1);
                beta[i] <= '0;
            end
        end else if (cfg_we) begin
            alpha[cfg_addr] <= cfg_alpha;
            beta[cfg_addr] <= cfg_beta;
        end

    always_ff @(posedge clk)
        if (rst) begin
            {v1, v2, out_valid, last1, last2, out_last} <= '0;
            out_data <= '0;
            grp <= '0;
        end else if (en) begin
            v1 <= in_valid;
            last1 <= in_valid & in_last;
            v2 <= v1;
            last2 <= last1;
            out_valid <= v2;
            out_last <= last2;
            for (int l = 0; l < LANES; l++) begin
                p1[l] <= prod[l];
                b1[l] <= beta[idx[l]];
                r2[l] <= rnd[l];
                out_data[l*DATA_WIDTH +: DATA_WIDTH] <= q[l];
            end
            if (in_valid) grp <= (in_last || grp + 1'b1 >= ngrp) ? '0 : grp + 1'b1;
        end

`ifdef PPU_SAT_STATS_EN
    logic [LANES-1:0] sat, sat3;
    logic [16:0] sum;

    always_comb begin
        sum = {1'b0, sat_count};
        for (int l = 0; l < LANES; l++) begin
            sat[l] = (r2[l] < lo) || (r2[l] > hi);
            sum = sum + 17'(sat3[l]);
        end
    end

    // clear beats a same-cycle increment; the count sticks at all-ones
    always_ff @(posedge clk)
        if (rst) begin
            sat3 <= '0;
            sat_count <= '0;
        end else begin
            if (en) sat3 <= sat;
            sat_count <= cfg_sat_clr ? '0 : !(out_valid && out_ready) ? sat_count : sum[16] ? '1 : sum[15:0];
        end
`else
    logic unused_sat_clr;
    assign unused_sat_clr = cfg_sat_clr;
    assign sat_count = '0;
`endif
endmodule
